multdiv_iterative: RTL and testbench

MULTDIV_ITERATIVE -- requirements
Module: multdiv_iterative

---
 rtl/multdiv_iterative.sv | 179 +++++++++++++++++
 tb/tb_multdiv_iterative.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_iterative.sv
// rtl/multdiv_iterative.sv - iterative signed 32x16 multiply and 32/16 divide unit
// Radix-2 shift-add multiply and restoring divide on magnitudes, one bit per clock.

module multdiv_iterative (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [15:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic [31:0] data_remainder,
    output logic        data_resultRDY,
    output logic        data_exception,
    output logic        op_is_div,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [5:0]  cnt;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [15:0] mplier;
    logic [31:0] quo;
    logic [15:0] dvsr;
    logic [15:0] prem;
    logic        sign_a;
    logic        sign_b;
    logic        is_div_q;
    logic        illegal_q;

    logic        can_start;
    logic        start;
    logic        abort_div;
    logic [31:0] addend;
    logic [16:0] r2;
    logic        r_ge;
    logic [15:0] r_diff;

    assign can_start = (state == S_IDLE) || (state == S_DONE);
    assign start     = can_start && (ctrl_MULT || ctrl_DIV);
    // Illegal starts ride through the DIV state for one cycle so they share the divide-by-zero exit.
    assign abort_div = illegal_q || (dvsr == 16'd0);
    assign busy      = (state == S_MULT) || (state == S_DIV) || (state == S_FIXUP);

    always_comb begin
        addend = 32'd0;
        // Bit 15 of B carries weight -2^15, so the final partial product is subtracted.
        if (mplier[0]) begin
            addend = (cnt == 6'd15) ? (32'd0 - mcand) : mcand;
        end
        r2     = {prem, quo[31]};
        r_ge   = (r2 >= {1'b0, dvsr});
        r_diff = r2[15:0] - dvsr;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = (ctrl_MULT && !ctrl_DIV) ? S_MULT : S_DIV;
                end
            end
            S_MULT: begin
                if (cnt == 6'd16) begin
                    state_next = S_FIXUP;
                end
            end
            S_DIV: begin
                if (abort_div || (cnt == 6'd32)) begin
                    state_next = S_FIXUP;
                end
            end
            S_FIXUP: state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= 6'd0;
            acc            <= 32'd0;
            mcand          <= 32'd0;
            mplier         <= 16'd0;
            quo            <= 32'd0;
            dvsr           <= 16'd0;
            prem           <= 16'd0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            is_div_q       <= 1'b0;
            illegal_q      <= 1'b0;
            data_result    <= 32'd0;
            data_remainder <= 32'd0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            op_is_div      <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cnt       <= 6'd0;
                        acc       <= 32'd0;
                        mcand     <= data_operandA;
                        mplier    <= data_operandB;
                        quo       <= data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
                        dvsr      <= data_operandB[15] ? (16'd0 - data_operandB) : data_operandB;
                        prem      <= 16'd0;
                        sign_a    <= data_operandA[31];
                        sign_b    <= data_operandB[15];
                        is_div_q  <= ctrl_DIV && !ctrl_MULT;
                        illegal_q <= ctrl_DIV && ctrl_MULT;
                    end
                end
                S_MULT: begin
                    if (cnt != 6'd16) begin
                        acc    <= acc + addend;
                        mcand  <= {mcand[30:0], 1'b0};
                        mplier <= {1'b0, mplier[15:1]};
                        cnt    <= cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    if (!abort_div && (cnt != 6'd32)) begin
                        prem <= r_ge ? r_diff : r2[15:0];
                        quo  <= {quo[30:0], r_ge};
                        cnt  <= cnt + 6'd1;
                    end
                end
                S_FIXUP: begin
                    data_resultRDY <= 1'b1;
                    if (illegal_q) begin
                        data_result    <= 32'd0;
                        data_remainder <= 32'd0;
                        data_exception <= 1'b1;
                        op_is_div      <= 1'b0;
                    end else if (is_div_q) begin
                        op_is_div <= 1'b1;
                        if (dvsr == 16'd0) begin
                            data_result    <= 32'd0;
                            data_remainder <= 32'd0;
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= (sign_a ^ sign_b) ? (32'd0 - quo) : quo;
                            data_remainder <= sign_a ? (32'd0 - {16'd0, prem}) : {16'd0, prem};
                            data_exception <= 1'b0;
                        end
                    end else begin
                        data_result    <= acc;
                        data_remainder <= 32'd0;
                        data_exception <= 1'b0;
                        op_is_div      <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_iterative.sv
// tb/tb_multdiv_iterative.sv - scoreboard bench for multdiv_iterative
module tb_multdiv_iterative;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [15:0] data_operandB = 16'd0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_resultRDY;
    logic        data_exception;
    logic        op_is_div;
    logic        busy;

    multdiv_iterative dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .op_is_div      (op_is_div),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        bit          m;
        bit          d;
        logic [31:0] res;
        logic [31:0] rem;
        bit          exc;
        bit          opdiv;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] last_res = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint mod31(input longint x);
        return ((x % 64'sd31) + 64'sd31) % 64'sd31;
    endfunction

    // Reference model; the due field carries the latency from the start edge.
    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input bit m, input bit d);
        exp_t   e;
        longint sa;
        longint sbv;
        longint p;
        longint q;
        longint r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.a = a; e.b = b; e.m = m; e.d = d;
        if (m && d) begin
            e.res = 32'd0; e.rem = 32'd0; e.exc = 1'b1; e.opdiv = 1'b0; e.due = 2;
        end else if (m) begin
            p = sa * sbv;
            e.res = p[31:0]; e.rem = 32'd0; e.exc = 1'b0; e.opdiv = 1'b0; e.due = 18;
        end else if (sbv == 0) begin
            e.res = 32'd0; e.rem = 32'd0; e.exc = 1'b1; e.opdiv = 1'b1; e.due = 2;
        end else begin
            q = sa / sbv;
            r = sa % sbv;
            e.res = q[31:0]; e.rem = r[31:0]; e.exc = 1'b0; e.opdiv = 1'b1; e.due = 34;
        end
        return e;
    endfunction

    exp_t   mon_e;
    longint ma, mb, mr, mq, mp;

    always @(negedge clock) begin
        if (reset_n && data_resultRDY) begin
            if (sb.size() == 0) begin
                check("spurious_rdy", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result", data_result, mon_e.res);
                check("remainder", data_remainder, mon_e.rem);
                check("exception", data_exception, mon_e.exc);
                check("op_is_div", op_is_div, mon_e.opdiv);
                check("latency", cyc, mon_e.due);
                check("busy_at_rdy", busy, 64'd0);
                ma = longint'($signed(mon_e.a));
                mb = longint'($signed(mon_e.b));
                mr = longint'($signed(data_remainder));
                mq = longint'($signed(data_result));
                mp = ma * mb;
                if (!mon_e.exc && mon_e.d && !(mon_e.a == 32'h8000_0000 && mon_e.b == 16'hFFFF)) begin
                    check("div_residue31", mod31(ma - mr), mod31(mq * mb));
                end
                if (!mon_e.exc && mon_e.m && mp >= -64'sd2147483648 && mp <= 64'sd2147483647) begin
                    check("mul_residue31", mod31(mq), mod31(mp));
                end
                last_res = mon_e.res;
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [15:0] b, input bit m, input bit d,
                         input int inject);
        exp_t e;
        bit   done;
        e = model(a, b, m, d);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        e.due = cyc + 1 + e.due;
        sb.push_back(e);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = 16'($urandom);
        check("busy_after_start", busy, 64'd1);
        @(negedge clock);
        check("held_result", data_result, last_res);
        if (inject > 2) begin
            repeat (inject - 2) @(negedge clock);
            ctrl_DIV      = 1'b1;
            data_operandB = 16'h0003;
            @(negedge clock);
            ctrl_DIV = 1'b0;
        end
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            check("rdy_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [15:0] b;
        int          sel;

        repeat (3) @(negedge clock);
        check("rst_result", data_result, 64'd0);
        check("rst_remainder", data_remainder, 64'd0);
        check("rst_rdy", data_resultRDY, 64'd0);
        check("rst_exception", data_exception, 64'd0);
        check("rst_op_is_div", op_is_div, 64'd0);
        check("rst_busy", busy, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        do_op(32'd7, 16'hFFFD, 1'b1, 1'b0, 0);
        do_op(32'hFFFF_FFEF, 16'd5, 1'b0, 1'b1, 0);
        do_op(32'h8000_0000, 16'hFFFF, 1'b0, 1'b1, 0);
        do_op(32'd1234, 16'd0, 1'b0, 1'b1, 0);
        do_op(32'h1234_5678, 16'h1234, 1'b1, 1'b0, 5);
        do_op(32'd5, 16'd7, 1'b1, 1'b1, 0);
        do_op(32'h7FFF_FFFF, 16'h7FFF, 1'b1, 1'b0, 0);
        do_op(32'h7FFF_FFFF, 16'h8000, 1'b0, 1'b1, 0);

        // Abort a divide with reset at E10; no RDY may follow.
        do_op(32'h0000_1000, 16'd3, 1'b1, 1'b0, 0);
        data_operandA = 32'hFFFE_7960;
        data_operandB = 16'd7;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (9) @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_result", data_result, 64'd0);
        check("arst_remainder", data_remainder, 64'd0);
        check("arst_rdy", data_resultRDY, 64'd0);
        check("arst_exception", data_exception, 64'd0);
        check("arst_op_is_div", op_is_div, 64'd0);
        check("arst_busy", busy, 64'd0);
        ctrl_MULT = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("rst_hold_rdy", data_resultRDY, 64'd0);
        end
        ctrl_MULT = 1'b0;
        reset_n   = 1'b1;
        last_res  = 32'd0;
        @(negedge clock);
        check("post_rst_idle", busy, 64'd0);
        do_op(32'h0001_0000, 16'h7FFF, 1'b1, 1'b0, 0);

        for (int n = 0; n < 1500; n++) begin
            a   = $urandom;
            b   = 16'($urandom);
            sel = $urandom_range(0, 99);
            case ($urandom_range(0, 15))
                0: a = 32'h8000_0000;
                1: a = 32'h7FFF_FFFF;
                2: b = 16'hFFFF;
                3: b = 16'h8000;
                4: b = 16'd1;
                5: a = 32'($urandom_range(0, 40));
                default: ;
            endcase
            if (sel < 5)       do_op(a, b, 1'b1, 1'b1, 0);
            else if (sel < 10) do_op(a, 16'd0, 1'b0, 1'b1, 0);
            else if (sel < 55) do_op(a, b, 1'b1, 1'b0, 0);
            else               do_op(a, b, 1'b0, 1'b1, 0);
        end

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
